// File: rtl/obstacle_manager_pkg.sv
// Shared types and constants for the obstacle manager: slot layout, FSM states
// and the lane-mapping helper.
package obstacle_pkg;

    localparam int OBSTACLE_COUNT = 10;
    localparam int OBS_BITS       = 15;

    localparam int TYPE_MSB   = 14;
    localparam int TYPE_LSB   = 13;
    localparam int POS_MSB    = 12;
    localparam int POS_LSB    = 3;
    localparam int LANE_MSB   = 2;
    localparam int LANE_LSB   = 1;
    localparam int ACTIVE_BIT = 0;

    localparam int LANE_COUNT     = 3;
    localparam int OBSTACLE_WIDTH = 246;

    typedef struct packed {
        logic [1:0] otype;
        logic [9:0] pos;
        logic [1:0] lane;
        logic       active;
    } obstacle_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_SPAWN  = 2'd2
    } state_t;

    // Raw 2-bit lane codes beyond the last real lane fold onto lane 1.
    function automatic logic [1:0] map_lane(input logic [1:0] raw);
        return (raw >= 2'(LANE_COUNT)) ? 2'd1 : raw;
    endfunction

endpackage

// File: rtl/obstacle_manager_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances one step when asked.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/obstacle_manager.sv
// Per-frame obstacle update: scrolls ten slots one per cycle after each vsync
// tick, then optionally spawns a new obstacle at the far edge.
module obstacle_manager
    import obstacle_pkg::*;
#(
    parameter logic [9:0]  SPAWN_POS = 10'd1023,
    parameter int unsigned MIN_GAP   = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                             system_clock_in,
    input  logic                             reset_n_in,
    input  logic                             vsync,
    input  logic                             enable_in,
    input  logic                             clear_in,
    input  logic [3:0]                       speed_in,
    output obstacle_t [OBSTACLE_COUNT-1:0]   obstacles,
    output logic                             obstacle_passed_out,
    output logic                             busy_out
);

    state_t                          state_q, state_d;
    obstacle_t [OBSTACLE_COUNT-1:0]  obst_q, obst_d;
    logic [3:0]                      idx_q, idx_d;
    logic [3:0]                      speed_q, speed_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic                            vsync_q, vsync_d;
    logic                            passed_q, passed_d;

    logic [15:0] lfsr_state;
    logic        lfsr_step;
    logic        tick;
    logic [3:0]  free_idx;
    logic        free_ok;
    obstacle_t   cur;
    logic        unused_lfsr_bits;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock   (system_clock_in),
        .reset_n (reset_n_in),
        .step    (lfsr_step),
        .state   (lfsr_state)
    );

    assign unused_lfsr_bits = ^lfsr_state[15:9];

    assign tick = vsync_q & ~vsync & enable_in;

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = 4'd0;
        free_ok  = 1'b0;
        for (int i = OBSTACLE_COUNT - 1; i >= 0; i--) begin
            if (!obst_q[i].active) begin
                free_idx = 4'(i);
                free_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        obst_d    = obst_q;
        idx_d     = idx_q;
        speed_d   = speed_q;
        cnt_d     = cnt_q;
        passed_d  = 1'b0;
        lfsr_step = 1'b0;
        vsync_d   = vsync;
        cur       = obst_q[idx_q];

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCROLL;
                    speed_d = speed_in;
                    idx_d   = 4'd0;
                end
            end
            ST_SCROLL: begin
                if (cur.active) begin
                    if (cur.pos >= {6'd0, speed_q}) begin
                        obst_d[idx_q].pos = cur.pos - {6'd0, speed_q};
                    end else begin
                        obst_d[idx_q].active = 1'b0;
                        passed_d             = 1'b1;
                    end
                end
                if (idx_q == 4'(OBSTACLE_COUNT - 1)) begin
                    state_d = ST_SPAWN;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_SPAWN: begin
                lfsr_step = 1'b1;
                state_d   = ST_IDLE;
                // A count of 1 reaches zero on this visit, so it spawns now.
                if (cnt_q <= 16'd1) begin
                    cnt_d = 16'(MIN_GAP) + 16'(lfsr_state[8:4]);
                    if (free_ok) begin
                        obst_d[free_idx].otype  = lfsr_state[3:2];
                        obst_d[free_idx].pos    = SPAWN_POS;
                        obst_d[free_idx].lane   = map_lane(lfsr_state[1:0]);
                        obst_d[free_idx].active = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides the whole update, including any spawn this cycle.
        if (clear_in) begin
            obst_d = obst_q;
            for (int i = 0; i < OBSTACLE_COUNT; i++) begin
                obst_d[i].active = 1'b0;
            end
            state_d   = ST_IDLE;
            cnt_d     = 16'(MIN_GAP);
            passed_d  = 1'b0;
            lfsr_step = 1'b0;
        end
    end

    always_ff @(posedge system_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            obst_q   <= '0;
            idx_q    <= 4'd0;
            speed_q  <= 4'd0;
            cnt_q    <= 16'(MIN_GAP);
            vsync_q  <= 1'b1;
            passed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            obst_q   <= obst_d;
            idx_q    <= idx_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            vsync_q  <= vsync_d;
            passed_q <= passed_d;
        end
    end

    assign obstacles           = obst_q;
    assign obstacle_passed_out = passed_q;
    assign busy_out            = (state_q != ST_IDLE);

endmodule
